// File: rtl/ysyx_23060059_axi_sram.sv
// AXI4 responder over an on-chip 64-bit SRAM with independent read/write channel FSMs
// and programmable response latency; each FSM state is exported on a debug port.
module ysyx_23060059_axi_sram #(
    parameter logic [31:0] MEM_BASE      = 32'h8000_0000,
    parameter int          DEPTH_LOG2    = 12,
    parameter int          READ_LATENCY  = 0,
    parameter int          WRITE_LATENCY = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    output logic        arready,
    output logic        rvalid,
    output logic [1:0]  rresp,
    output logic [63:0] rdata,
    output logic        rlast,
    output logic [3:0]  rid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    output logic        awready,
    input  logic        wvalid,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        wlast,
    output logic        wready,
    output logic        bvalid,
    output logic [1:0]  bresp,
    output logic [3:0]  bid,
    input  logic        bready,
    output logic [1:0]  dbg_r_state,
    output logic [1:0]  dbg_w_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid and its payload stay stable until then, and ready never depends on valid.
    localparam int          DEPTH       = 1 << DEPTH_LOG2;
    localparam logic [31:0] MEM_BYTES   = 32'd8 << DEPTH_LOG2;
    localparam logic [3:0]  RLAT        = 4'(READ_LATENCY);
    localparam logic [3:0]  WLAT        = 4'(WRITE_LATENCY);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    logic [63:0] mem [DEPTH];

    r_state_t              r_state, r_next;
    logic [31:0]           r_addr, r_off;
    logic [3:0]            r_id, r_cnt;
    logic [7:0]            r_len, r_beat;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  ar_hs, r_hs, r_last_beat, r_err, r_in_range;
    logic [DEPTH_LOG2-1:0] r_idx;

    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;

    // Errors are evaluated per beat so a burst running off the region end only fails the tail.
    always_comb begin
        r_off       = r_addr - MEM_BASE;
        r_in_range  = (r_addr >= MEM_BASE) && (r_off < MEM_BYTES);
        r_idx       = r_off[DEPTH_LOG2+2:3];
        r_err       = !r_in_range || (r_size > 3'd3) || (r_burst != BURST_INCR);
        r_last_beat = (r_beat == r_len);
    end

    assign rvalid      = (r_state == R_DATA);
    assign rlast       = rvalid && r_last_beat;
    assign rid         = rvalid ? r_id : 4'd0;
    assign rresp       = (rvalid && r_err) ? RESP_SLVERR : RESP_OKAY;
    assign rdata       = (rvalid && !r_err) ? mem[r_idx] : 64'd0;
    assign dbg_r_state = r_state;

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = (RLAT == 4'd0) ? R_DATA : R_WAIT;
            R_WAIT:  if (r_cnt <= 4'd1) r_next = R_DATA;
            R_DATA:  if (r_hs && r_last_beat) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            r_addr  <= 32'd0;
            r_id    <= 4'd0;
            r_len   <= 8'd0;
            r_size  <= 3'd0;
            r_burst <= 2'd0;
            r_beat  <= 8'd0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= r_next;
            arready <= (r_next == R_IDLE);
            if (ar_hs) begin
                r_addr  <= araddr;
                r_id    <= arid;
                r_len   <= arlen;
                r_size  <= arsize;
                r_burst <= arburst;
                r_beat  <= 8'd0;
                r_cnt   <= RLAT;
            end else if (r_state == R_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end else if (r_hs && !r_last_beat) begin
                r_addr <= r_addr + (32'd1 << r_size);
                r_beat <= r_beat + 8'd1;
            end
        end
    end

    w_state_t              w_state, w_next;
    logic                  aw_done, w_done, aw_hs, w_hs, aw_have, w_have, w_commit, w_err, w_in_range;
    logic [31:0]           aw_addr_q, e_addr, w_off;
    logic [3:0]            aw_id_q, e_id, b_id, w_cnt;
    logic [7:0]            aw_len_q, e_len, w_strb_q, e_strb;
    logic [2:0]            aw_size_q, e_size;
    logic [1:0]            aw_burst_q, e_burst, b_resp;
    logic [63:0]           w_data_q, e_data;
    logic [DEPTH_LOG2-1:0] w_idx;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // Effective AW/W fields bypass the holding registers so a handshake can commit on its own edge.
    always_comb begin
        aw_have    = aw_done || aw_hs;
        w_have     = w_done || (w_hs && wlast);
        e_addr     = aw_hs ? awaddr  : aw_addr_q;
        e_id       = aw_hs ? awid    : aw_id_q;
        e_len      = aw_hs ? awlen   : aw_len_q;
        e_size     = aw_hs ? awsize  : aw_size_q;
        e_burst    = aw_hs ? awburst : aw_burst_q;
        e_data     = w_hs  ? wdata   : w_data_q;
        e_strb     = w_hs  ? wstrb   : w_strb_q;
        w_off      = e_addr - MEM_BASE;
        w_in_range = (e_addr >= MEM_BASE) && (w_off < MEM_BYTES);
        w_idx      = w_off[DEPTH_LOG2+2:3];
        w_err      = !w_in_range || (e_size > 3'd3) || (e_burst != BURST_INCR) || (e_len != 8'd0);
        w_commit   = (w_state == W_IDLE) && aw_have && w_have;
    end

    assign bvalid      = (w_state == W_RESP);
    assign bid         = bvalid ? b_id : 4'd0;
    assign bresp       = bvalid ? b_resp : RESP_OKAY;
    assign dbg_w_state = w_state;

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (w_commit) w_next = (WLAT == 4'd0) ? W_RESP : W_WAIT;
            W_WAIT:  if (w_cnt <= 4'd1) w_next = W_RESP;
            W_RESP:  if (bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_state    <= W_IDLE;
            awready    <= 1'b0;
            wready     <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            aw_addr_q  <= 32'd0;
            aw_id_q    <= 4'd0;
            aw_len_q   <= 8'd0;
            aw_size_q  <= 3'd0;
            aw_burst_q <= 2'd0;
            w_data_q   <= 64'd0;
            w_strb_q   <= 8'd0;
            w_cnt      <= 4'd0;
            b_id       <= 4'd0;
            b_resp     <= RESP_OKAY;
        end else begin
            w_state <= w_next;
            awready <= (w_next == W_IDLE) && !aw_have;
            wready  <= (w_next == W_IDLE) && !w_have;
            if (w_commit) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                b_id    <= e_id;
                b_resp  <= w_err ? RESP_SLVERR : RESP_OKAY;
                w_cnt   <= WLAT;
            end else begin
                if (w_state == W_WAIT) w_cnt <= w_cnt - 4'd1;
                if (aw_hs) begin
                    aw_done    <= 1'b1;
                    aw_addr_q  <= awaddr;
                    aw_id_q    <= awid;
                    aw_len_q   <= awlen;
                    aw_size_q  <= awsize;
                    aw_burst_q <= awburst;
                end
                if (w_hs) begin
                    w_data_q <= wdata;
                    w_strb_q <= wstrb;
                    if (wlast) w_done <= 1'b1;
                end
            end
        end
    end

    // Storage is never reset; a commit cannot occur while reset holds the handshakes off.
    always_ff @(posedge clock) begin
        if (w_commit && !w_err) begin
            for (int i = 0; i < 8; i++) begin
                if (e_strb[i]) mem[w_idx][8*i +: 8] <= e_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060059_axi_sram.sv
// Scenario bench for the AXI SRAM responder: latency-0 instance for function, latency 3/2 instance for timing.
module tb_ysyx_23060059_axi_sram;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] araddr, awaddr;
    logic [3:0]  arid, awid, rid, bid;
    logic [7:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp, dbg_r_state, dbg_w_state;
    logic        arvalid, arready, rvalid, rlast, rready, awvalid, awready;
    logic        wvalid, wlast, wready, bvalid, bready;
    logic [63:0] rdata, wdata;

    logic [31:0] l_araddr, l_awaddr;
    logic [3:0]  l_arid, l_awid, l_rid, l_bid;
    logic [7:0]  l_arlen, l_awlen, l_wstrb;
    logic [2:0]  l_arsize, l_awsize;
    logic [1:0]  l_arburst, l_awburst, l_rresp, l_bresp, l_dbg_r_state, l_dbg_w_state;
    logic        l_arvalid, l_arready, l_rvalid, l_rlast, l_rready, l_awvalid, l_awready;
    logic        l_wvalid, l_wlast, l_wready, l_bvalid, l_bready;
    logic [63:0] l_rdata, l_wdata;

    int checks = 0;
    int errors = 0;
    logic [63:0] model [int];
    logic [70:0] exp_r_q[$];
    logic [5:0]  exp_b_q[$];

    ysyx_23060059_axi_sram u_dut (
        .clock(clock), .reset(reset),
        .araddr(araddr), .arvalid(arvalid), .arid(arid), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arready(arready),
        .rvalid(rvalid), .rresp(rresp), .rdata(rdata), .rlast(rlast), .rid(rid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awid(awid), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wready(wready),
        .bvalid(bvalid), .bresp(bresp), .bid(bid), .bready(bready),
        .dbg_r_state(dbg_r_state), .dbg_w_state(dbg_w_state)
    );

    ysyx_23060059_axi_sram #(.READ_LATENCY(3), .WRITE_LATENCY(2)) u_lat (
        .clock(clock), .reset(reset),
        .araddr(l_araddr), .arvalid(l_arvalid), .arid(l_arid), .arlen(l_arlen), .arsize(l_arsize),
        .arburst(l_arburst), .arready(l_arready),
        .rvalid(l_rvalid), .rresp(l_rresp), .rdata(l_rdata), .rlast(l_rlast), .rid(l_rid), .rready(l_rready),
        .awaddr(l_awaddr), .awvalid(l_awvalid), .awid(l_awid), .awlen(l_awlen), .awsize(l_awsize),
        .awburst(l_awburst), .awready(l_awready),
        .wvalid(l_wvalid), .wdata(l_wdata), .wstrb(l_wstrb), .wlast(l_wlast), .wready(l_wready),
        .bvalid(l_bvalid), .bresp(l_bresp), .bid(l_bid), .bready(l_bready),
        .dbg_r_state(l_dbg_r_state), .dbg_w_state(l_dbg_w_state)
    );

    function automatic logic in_range(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'h8000);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    function automatic logic [63:0] model_rd(input logic [31:0] a);
        int i;
        i = widx(a);
        if (model.exists(i)) return model[i];
        return 64'h0;
    endfunction

    function automatic void model_wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        int i;
        logic [63:0] cur;
        i = widx(a);
        cur = model.exists(i) ? model[i] : 64'h0;
        for (int b = 0; b < 8; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
        model[i] = cur;
    endfunction

    function automatic void push_r(input logic [31:0] a, input logic [3:0] id, input logic last);
        if (in_range(a)) exp_r_q.push_back({id, 2'b00, last, model_rd(a)});
        else exp_r_q.push_back({id, 2'b10, last, 64'h0});
    endfunction

    task automatic send_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bt);
        int n;
        awaddr = a; awid = id; awlen = len; awsize = sz; awburst = bt; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 100) begin @(negedge clock); n++; end
        checks++;
        if (!awready) begin errors++; $display("FAIL aw_accept: awready=%0b required 1", awready); end
        @(negedge clock);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] d, input logic [7:0] s, input logic last);
        int n;
        wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
        n = 0;
        while (!wready && n < 100) begin @(negedge clock); n++; end
        checks++;
        if (!wready) begin errors++; $display("FAIL w_accept: wready=%0b required 1", wready); end
        @(negedge clock);
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bt);
        int n;
        araddr = a; arid = id; arlen = len; arsize = sz; arburst = bt; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin @(negedge clock); n++; end
        checks++;
        if (!arready) begin errors++; $display("FAIL ar_accept: arready=%0b required 1", arready); end
        @(negedge clock);
        arvalid = 1'b0;
    endtask

    task automatic wait_b();
        int n;
        logic [5:0] e_v;
        n = 0;
        while (!bvalid && n < 100) begin @(negedge clock); n++; end
        e_v = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : 6'h0;
        checks++;
        if ({bvalid, bid, bresp} !== {1'b1, e_v})
            begin errors++; $display("FAIL b_resp: got valid/id/resp %h required %h", {bvalid, bid, bresp}, {1'b1, e_v}); end
        bready = 1'b1;
        @(negedge clock);
        bready = 1'b0;
    endtask

    task automatic recv_r(input int beats, input bit stall);
        int n;
        logic [70:0] e_v;
        for (int b = 0; b < beats; b++) begin
            n = 0;
            while (!rvalid && n < 100) begin @(negedge clock); n++; end
            e_v = (exp_r_q.size() > 0) ? exp_r_q.pop_front() : 71'h0;
            checks++;
            if ({rvalid, rid, rresp, rlast, rdata} !== {1'b1, e_v})
                begin errors++; $display("FAIL r_beat%0d: got valid/id/resp/last/data %h required %h", b, {rvalid, rid, rresp, rlast, rdata}, {1'b1, e_v}); end
            if (stall) begin
                @(negedge clock);
                checks++;
                if ({rvalid, rid, rresp, rlast, rdata} !== {1'b1, e_v})
                    begin errors++; $display("FAIL r_stall%0d: got %h required %h", b, {rvalid, rid, rresp, rlast, rdata}, {1'b1, e_v}); end
            end
            rready = 1'b1;
            @(negedge clock);
            rready = 1'b0;
        end
    endtask

    task automatic write_seq(input logic [31:0] a, input logic [3:0] id, input logic [63:0] d,
                             input logic [7:0] s, input logic [1:0] resp);
        if (resp == 2'b00) model_wr(a, d, s);
        exp_b_q.push_back({id, resp});
        send_aw(a, id, 8'd0, 3'd3, 2'b01);
        send_w(d, s, 1'b1);
        wait_b();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if ({arready, awready, wready, rvalid, bvalid, rlast, rresp, bresp, rid, bid, rdata} !== '0)
            begin errors++; $display("FAIL reset_outputs: got %h required 0", {arready, awready, wready, rvalid, bvalid, rlast, rresp, bresp, rid, bid, rdata}); end
        checks++;
        if ({l_arready, l_awready, l_wready, l_rvalid, l_bvalid, l_rlast, l_rdata} !== '0)
            begin errors++; $display("FAIL reset_outputs_lat: got %h required 0", {l_arready, l_awready, l_wready, l_rvalid, l_bvalid, l_rlast, l_rdata}); end
        reset = 1'b1;
        #1;
        checks++;
        if (arready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: arready=%0b required 0", arready); end
        @(negedge clock);
        checks++;
        if ({arready, awready, wready, l_arready, l_awready, l_wready} !== 6'b111111)
            begin errors++; $display("FAIL ready_after_edge: got %b required 111111", {arready, awready, wready, l_arready, l_awready, l_wready}); end
    endtask

    task automatic test_init();
        for (int i = 0; i < 4; i++) write_seq(BASE + 32'(i * 8), 4'(i), {$urandom, $urandom}, 8'hFF, 2'b00);
        write_seq(BASE + 32'h7FF8, 4'hE, {$urandom, $urandom}, 8'hFF, 2'b00);
    endtask

    task automatic test_write_read();
        int n;
        model_wr(BASE + 32'd4, 64'h11223344_00000000, 8'hF0);
        exp_b_q.push_back({4'd3, 2'b00});
        awaddr = BASE + 32'd4; awid = 4'd3; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        wdata = 64'h11223344_00000000; wstrb = 8'hF0; wlast = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 100) begin @(negedge clock); n++; end
        @(negedge clock);
        awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
        wait_b();
        push_r(BASE + 32'd4, 4'd0, 1'b1);
        send_ar(BASE + 32'd4, 4'd0, 8'd0, 3'd2, 2'b01);
        recv_r(1, 1'b0);
    endtask

    task automatic test_w_before_aw();
        logic [63:0] d;
        logic seen;
        d = {$urandom, $urandom};
        send_w(d, 8'h3C, 1'b1);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if ({wready, awready, bvalid} !== 3'b010)
                begin errors++; $display("FAIL w_first_ready: wready/awready/bvalid=%b required 010", {wready, awready, bvalid}); end
            @(negedge clock);
        end
        model_wr(BASE + 32'd8, d, 8'h3C);
        exp_b_q.push_back({4'd5, 2'b00});
        send_aw(BASE + 32'd8, 4'd5, 8'd0, 3'd3, 2'b01);
        wait_b();
        seen = 1'b0;
        repeat (4) begin @(negedge clock); if (bvalid) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL extra_b: bvalid seen=%0b required 0", seen); end
        push_r(BASE + 32'd8, 4'd5, 1'b1);
        send_ar(BASE + 32'd8, 4'd5, 8'd0, 3'd3, 2'b01);
        recv_r(1, 1'b0);
    endtask

    task automatic test_burst();
        for (int i = 0; i < 4; i++) push_r(BASE + 32'(i * 8), 4'd2, i == 3);
        send_ar(BASE, 4'd2, 8'd3, 3'd3, 2'b01);
        recv_r(4, 1'b1);
    endtask

    task automatic test_errors();
        push_r(32'h2000_0000, 4'd7, 1'b1);
        send_ar(32'h2000_0000, 4'd7, 8'd0, 3'd3, 2'b01);
        recv_r(1, 1'b0);
        write_seq(32'h2000_0000, 4'd6, {$urandom, $urandom}, 8'hFF, 2'b10);
        push_r(BASE, 4'd0, 1'b1);
        send_ar(BASE, 4'd0, 8'd0, 3'd3, 2'b01);
        recv_r(1, 1'b0);
        exp_b_q.push_back({4'd4, 2'b10});
        send_aw(BASE + 32'd8, 4'd4, 8'd1, 3'd3, 2'b01);
        send_w({$urandom, $urandom}, 8'hFF, 1'b0);
        send_w({$urandom, $urandom}, 8'hFF, 1'b1);
        wait_b();
        push_r(BASE + 32'd8, 4'd4, 1'b1);
        send_ar(BASE + 32'd8, 4'd4, 8'd0, 3'd3, 2'b01);
        recv_r(1, 1'b0);
        exp_r_q.push_back({4'd1, 2'b10, 1'b1, 64'h0});
        send_ar(BASE, 4'd1, 8'd0, 3'd4, 2'b01);
        recv_r(1, 1'b0);
        exp_r_q.push_back({4'd2, 2'b10, 1'b1, 64'h0});
        send_ar(BASE, 4'd2, 8'd0, 3'd3, 2'b00);
        recv_r(1, 1'b0);
        push_r(BASE + 32'h7FF8, 4'd9, 1'b0);
        push_r(BASE + 32'h8000, 4'd9, 1'b1);
        send_ar(BASE + 32'h7FF8, 4'd9, 8'd1, 3'd3, 2'b01);
        recv_r(2, 1'b0);
    endtask

    task automatic test_latency();
        logic [63:0] d;
        logic [5:0]  eb;
        logic [70:0] er;
        d = {$urandom, $urandom};
        l_awaddr = BASE + 32'd16; l_awid = 4'hA; l_awlen = 8'd0; l_awsize = 3'd3; l_awburst = 2'b01; l_awvalid = 1'b1;
        l_wdata = d; l_wstrb = 8'hFF; l_wlast = 1'b1; l_wvalid = 1'b1;
        checks++;
        if ({l_awready, l_wready} !== 2'b11) begin errors++; $display("FAIL lat_w_ready: got %b required 11", {l_awready, l_wready}); end
        @(posedge clock);
        @(negedge clock);
        l_awvalid = 1'b0; l_wvalid = 1'b0; l_wlast = 1'b0;
        exp_b_q.push_back({4'hA, 2'b00});
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (l_bvalid !== 1'b0) begin errors++; $display("FAIL lat_b_early%0d: bvalid=%0b required 0", c, l_bvalid); end
            @(negedge clock);
        end
        eb = exp_b_q.pop_front();
        checks++;
        if ({l_bvalid, l_bid, l_bresp} !== {1'b1, eb})
            begin errors++; $display("FAIL lat_b: got %h required %h", {l_bvalid, l_bid, l_bresp}, {1'b1, eb}); end
        l_bready = 1'b1;
        @(negedge clock);
        l_bready = 1'b0;
        l_araddr = BASE + 32'd16; l_arid = 4'd1; l_arlen = 8'd0; l_arsize = 3'd3; l_arburst = 2'b01; l_arvalid = 1'b1;
        checks++;
        if (l_arready !== 1'b1) begin errors++; $display("FAIL lat_ar_ready: arready=%0b required 1", l_arready); end
        @(posedge clock);
        @(negedge clock);
        l_arvalid = 1'b0;
        exp_r_q.push_back({4'd1, 2'b00, 1'b1, d});
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (l_rvalid !== 1'b0) begin errors++; $display("FAIL lat_r_early%0d: rvalid=%0b required 0", c, l_rvalid); end
            @(negedge clock);
        end
        er = exp_r_q.pop_front();
        checks++;
        if ({l_rvalid, l_rid, l_rresp, l_rlast, l_rdata} !== {1'b1, er})
            begin errors++; $display("FAIL lat_r: got %h required %h", {l_rvalid, l_rid, l_rresp, l_rlast, l_rdata}, {1'b1, er}); end
        l_rready = 1'b1;
        @(negedge clock);
        l_rready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        logic seen;
        logic [63:0] d;
        send_aw(BASE + 32'd24, 4'd8, 8'd0, 3'd3, 2'b01);
        send_ar(BASE, 4'd1, 8'd0, 3'd3, 2'b01);
        n = 0;
        while (!rvalid && n < 100) begin @(negedge clock); n++; end
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({rvalid, arready, rlast, rdata, awready, wready, bvalid} !== '0)
            begin errors++; $display("FAIL mid_reset_outputs: got %h required 0", {rvalid, arready, rlast, rdata, awready, wready, bvalid}); end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (arready !== 1'b0) begin errors++; $display("FAIL mid_release_ready: arready=%0b required 0", arready); end
        @(negedge clock);
        checks++;
        if ({arready, awready, wready} !== 3'b111)
            begin errors++; $display("FAIL mid_ready_after_edge: got %b required 111", {arready, awready, wready}); end
        d = {$urandom, $urandom};
        send_w(d, 8'hFF, 1'b1);
        seen = 1'b0;
        repeat (4) begin if (rvalid || bvalid) seen = 1'b1; @(negedge clock); end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL stale_response: seen=%0b required 0", seen); end
        push_r(BASE + 32'd24, 4'd3, 1'b1);
        send_ar(BASE + 32'd24, 4'd3, 8'd0, 3'd3, 2'b01);
        recv_r(1, 1'b0);
        model_wr(BASE + 32'd32, d, 8'hFF);
        exp_b_q.push_back({4'd11, 2'b00});
        send_aw(BASE + 32'd32, 4'd11, 8'd0, 3'd3, 2'b01);
        wait_b();
        push_r(BASE + 32'd32, 4'd12, 1'b1);
        send_ar(BASE + 32'd32, 4'd12, 8'd0, 3'd3, 2'b01);
        recv_r(1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        araddr = '0; arvalid = 0; arid = '0; arlen = '0; arsize = '0; arburst = '0; rready = 0;
        awaddr = '0; awvalid = 0; awid = '0; awlen = '0; awsize = '0; awburst = '0;
        wvalid = 0; wdata = '0; wstrb = '0; wlast = 0; bready = 0;
        l_araddr = '0; l_arvalid = 0; l_arid = '0; l_arlen = '0; l_arsize = '0; l_arburst = '0; l_rready = 0;
        l_awaddr = '0; l_awvalid = 0; l_awid = '0; l_awlen = '0; l_awsize = '0; l_awburst = '0;
        l_wvalid = 0; l_wdata = '0; l_wstrb = '0; l_wlast = 0; l_bready = 0;
        test_reset();
        test_init();
        test_write_read();
        test_w_before_aw();
        test_burst();
        test_errors();
        test_latency();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
